// File: rtl/mips_isa_pkg.sv
// rtl/mips_isa_pkg.sv - MIPS_CPU instruction group constants and command encoder
// Purpose: opcode/funct/shamt constants, command op codes and the pure
//          command-to-word encoding used by mips_instr_encoder.
// Ports:   none (package).
package mips_isa_pkg;

    localparam logic [5:0]  OP_RTYPE    = 6'b000100;
    localparam logic [5:0]  OP_LW       = 6'b000101;
    localparam logic [5:0]  OP_SW       = 6'b000110;
    localparam logic [4:0]  SHAMT_RTYPE = 5'b01010;

    localparam logic [5:0]  FUNCT_ADD   = 6'd32;
    localparam logic [5:0]  FUNCT_SUB   = 6'd34;
    localparam logic [5:0]  FUNCT_AND   = 6'd36;
    localparam logic [5:0]  FUNCT_OR    = 6'd37;
    localparam logic [5:0]  FUNCT_MUL   = 6'd50;

    // Codes 1-5 match the ALU control codes of the CPU.
    localparam logic [2:0]  CMD_NOP     = 3'd0;
    localparam logic [2:0]  CMD_ADD     = 3'd1;
    localparam logic [2:0]  CMD_SUB     = 3'd2;
    localparam logic [2:0]  CMD_AND     = 3'd3;
    localparam logic [2:0]  CMD_OR      = 3'd4;
    localparam logic [2:0]  CMD_MUL     = 3'd5;
    localparam logic [2:0]  CMD_LW      = 3'd6;
    localparam logic [2:0]  CMD_SW      = 3'd7;

    localparam logic [31:0] INSTR_NOP   = 32'h0000_0000;

    function automatic logic [31:0] encode_cmd(
        input logic [2:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [5:0] funct;
        funct = FUNCT_ADD;
        case (op)
            CMD_SUB: funct = FUNCT_SUB;
            CMD_AND: funct = FUNCT_AND;
            CMD_OR:  funct = FUNCT_OR;
            CMD_MUL: funct = FUNCT_MUL;
            default: funct = FUNCT_ADD;
        endcase
        case (op)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_OR, CMD_MUL:
                encode_cmd = {OP_RTYPE, rs, rt, rd, SHAMT_RTYPE, funct};
            CMD_LW:  encode_cmd = {OP_LW, rs, rt, imm};
            CMD_SW:  encode_cmd = {OP_SW, rs, rt, imm};
            default: encode_cmd = INSTR_NOP;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy level
// Purpose: in-order storage of encoded words between accept and issue.
// Ports:   clk, rst (async, active-high); push/wdata write the tail,
//          pop advances the head; rdata is the head word; level, full, empty.
//          Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign level   = level_q;

    // Storage needs no reset: pointers and level alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (!do_push && do_pop) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - command-to-instruction encoder and issue buffer
// Purpose: encodes accepted commands into MIPS_CPU instruction words, buffers
//          them in a FIFO and issues them in order to the CPU fetch port.
// Option:  MIPS_INSTR_ENC_HAZARD_EN enables load-use bubble insertion.
// Ports:   clk, rst (async, active-high);
//          cmd_valid/cmd_ready with cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm;
//          instr_valid/instr_ready with instr;
//          fifo_level (occupied entries), issued_count (issue handshakes).
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [4:0]               cmd_rs,
    input  logic [4:0]               cmd_rt,
    input  logic [4:0]               cmd_rd,
    input  logic [15:0]              cmd_imm,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [31:0]              instr,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         issued_count
);

    logic        started;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        issue;
    logic        hazard;
    logic [31:0] head;
    logic [31:0] wdata;

    // Holds cmd_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    // Readiness follows occupancy only; a same-cycle pop never frees a slot.
    assign cmd_ready = started && !full;
    assign push      = cmd_valid && cmd_ready;
    assign wdata     = encode_cmd(cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (head),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign instr_valid = !empty;
    assign issue       = instr_valid && instr_ready;
    // A bubble is a handshake that leaves the head in place.
    assign pop         = issue && !hazard;
    assign instr       = (empty || hazard) ? INSTR_NOP : head;

`ifdef MIPS_INSTR_ENC_HAZARD_EN
    logic       last_lw_vld;
    logic [4:0] last_lw_rt;
    logic       reads_rs;
    logic       reads_rt;
    logic [5:0] head_op;
    logic [4:0] head_rs;
    logic [4:0] head_rt;

    assign head_op = head[31:26];
    assign head_rs = head[25:21];
    assign head_rt = head[20:16];

    always_comb begin
        reads_rs = 1'b0;
        reads_rt = 1'b0;
        case (head_op)
            OP_RTYPE: begin reads_rs = 1'b1; reads_rt = 1'b1; end
            OP_LW:    begin reads_rs = 1'b1; end
            OP_SW:    begin reads_rs = 1'b1; reads_rt = 1'b1; end
            default:  begin end
        endcase
    end

    // r0 is hardwired zero, so a load into it never creates a dependency.
    assign hazard = !empty && last_lw_vld && (last_lw_rt != 5'd0) &&
                    ((reads_rs && head_rs == last_lw_rt) ||
                     (reads_rt && head_rt == last_lw_rt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lw_vld <= 1'b0;
            last_lw_rt  <= 5'd0;
        end else if (issue) begin
            if (!hazard && head_op == OP_LW) begin
                last_lw_vld <= 1'b1;
                last_lw_rt  <= head_rt;
            end else begin
                last_lw_vld <= 1'b0;
                last_lw_rt  <= 5'd0;
            end
        end
    end
`else
    assign hazard = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_count <= '0;
        end else if (issue) begin
            issued_count <= issued_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// tb/tb_mips_instr_encoder.sv - scoreboard bench for mips_instr_encoder
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [15:0] cmd_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [2:0]  fifo_level;
    logic [15:0] issued_count;

    int          checks = 0;
    int          errors = 0;
    int          ready_mode = 0;
    logic [31:0] exp_q[$];
    logic [15:0] model_issued = 16'd0;
    logic        m_lw_vld = 1'b0;
    logic [4:0]  m_lw_rt = 5'd0;

    mips_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rs       (cmd_rs),
        .cmd_rt       (cmd_rt),
        .cmd_rd       (cmd_rd),
        .cmd_imm      (cmd_imm),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .fifo_level   (fifo_level),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from field positions with plain arithmetic.
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int imm);
        int funct;
        case (op)
            1: funct = 32;
            2: funct = 34;
            3: funct = 36;
            4: funct = 37;
            default: funct = 50;
        endcase
        if (op == 0) return 32'd0;
        if (op == 6) return 32'(5 * 2**26 + rs * 2**21 + rt * 2**16 + imm);
        if (op == 7) return 32'(6 * 2**26 + rs * 2**21 + rt * 2**16 + imm);
        return 32'(4 * 2**26 + rs * 2**21 + rt * 2**16 + rd * 2**11 + 10 * 2**6 + funct);
    endfunction

    // Issue order equals accept order, so the bubble decision is made at push time
    // against the previously pushed word.
    task automatic model_push(input int op, input int rs, input int rt, input int rd, input int imm);
        bit uses;
        uses = 1'b0;
        if (op >= 1 && op <= 5) uses = (rs == m_lw_rt) || (rt == m_lw_rt);
        if (op == 6)            uses = (rs == m_lw_rt);
        if (op == 7)            uses = (rs == m_lw_rt) || (rt == m_lw_rt);
`ifdef MIPS_INSTR_ENC_HAZARD_EN
        if (m_lw_vld && m_lw_rt != 5'd0 && uses) exp_q.push_back(32'd0);
`endif
        m_lw_vld = (op == 6);
        m_lw_rt  = 5'(rt);
        exp_q.push_back(ref_word(op, rs, rt, rd, imm));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd, input int imm);
        cmd_op    = 3'(op);
        cmd_rs    = 5'(rs);
        cmd_rt    = 5'(rt);
        cmd_rd    = 5'(rd);
        cmd_imm   = 16'(imm);
        cmd_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                model_push(op, rs, rt, rd, imm);
                tick();
                cmd_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("send_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (fifo_level == 3'd0 && !instr_valid) return;
        end
        chk("drain_timeout", 32'd0, 32'd1);
    endtask

    // Sole driver of instr_ready; updated a little after each rising edge.
    initial begin
        instr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       instr_ready = 1'b0;
                1:       instr_ready = 1'b1;
                default: instr_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    // Monitor: sampled on the falling edge, so a valid&&ready seen here
    // is the handshake of the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("issued_count", 32'(issued_count), 32'(model_issued));
            if (instr_valid) begin
                if (instr_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: got 0x%08h expected no word", instr);
                    end else begin
                        chk("issue_word", instr, exp_q.pop_front());
                    end
                    model_issued = model_issued + 16'd1;
                end
            end else begin
                chk("empty_instr", instr, 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rs    = 5'd0;
        cmd_rt    = 5'd0;
        cmd_rd    = 5'd0;
        cmd_imm   = 16'd0;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_count", 32'(issued_count), 32'd0);
        rst = 1'b0;
        chk("release_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("first_clk_cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed encodings, one word at a time with one-cycle latency.
        ready_mode = 1;
        tick();
        send(1, 1, 2, 3, 16'h5555);
        chk("add_valid", 32'(instr_valid), 32'd1);
        chk("add_word", instr, 32'h10221AA0);
        tick();
        chk("add_count", 32'(issued_count), 32'd1);
        send(7, 4, 5, 9, 16'hFFFC);
        chk("sw_word", instr, 32'h1885FFFC);
        tick();
        send(6, 4, 5, 9, 16'h0010);
        chk("lw_word", instr, 32'h14850010);
        tick();
        send(5, 1, 2, 3, 16'h0);
        chk("mul_word", instr, 32'h10221AB2);
        tick();
        send(0, 31, 31, 31, 16'hFFFF);
        chk("nop_valid", 32'(instr_valid), 32'd1);
        chk("nop_word", instr, 32'd0);
        drain();

        // Fill to full with the issue side stalled.
        ready_mode = 0;
        repeat (2) tick();
        send(2, 3, 4, 5, 0);
        send(3, 6, 7, 8, 0);
        send(4, 9, 10, 11, 0);
        send(1, 12, 13, 14, 0);
        cmd_op = 3'd1; cmd_rs = 5'd15; cmd_rt = 5'd16; cmd_rd = 5'd17; cmd_imm = 16'd0;
        cmd_valid = 1'b1;
        repeat (2) tick();
        chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("stall_head", instr, exp_q[0]);
        ready_mode = 1;
        #2;
        chk("full_pop_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("after_pop_level", 32'(fifo_level), 32'd3);
        chk("after_pop_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        send(1, 15, 16, 17, 0);
        drain();

        // Load-use dependency, then a load into r0.
        base = int'(model_issued);
        send(6, 3, 5, 0, 16'h1234);
        send(1, 5, 6, 7, 0);
        drain();
`ifdef MIPS_INSTR_ENC_HAZARD_EN
        chk("hazard_count", 32'(issued_count), 32'(base + 3));
`else
        chk("hazard_count", 32'(issued_count), 32'(base + 2));
`endif
        base = int'(model_issued);
        send(6, 3, 0, 0, 16'h0004);
        send(1, 0, 6, 7, 0);
        drain();
        chk("r0_no_bubble", 32'(issued_count), 32'(base + 2));

        // Randomized traffic with random backpressure.
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            send($urandom % 8, $urandom % 8, $urandom % 8, $urandom % 32, $urandom % 65536);
            repeat ($urandom % 3) tick();
        end
        drain();

        // Asynchronous reset with entries queued.
        ready_mode = 0;
        repeat (2) tick();
        send(1, 1, 2, 3, 0);
        send(6, 4, 5, 0, 8);
        send(7, 4, 5, 0, 12);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'd0);
        chk("arst_level", 32'(fifo_level), 32'd0);
        chk("arst_count", 32'(issued_count), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        model_issued = 16'd0;
        m_lw_vld     = 1'b0;
        m_lw_rt      = 5'd0;
        tick();
        rst = 1'b0;
        ready_mode = 1;
        repeat (4) tick();
        chk("post_rst_valid", 32'(instr_valid), 32'd0);
        chk("post_rst_instr", instr, 32'd0);
        chk("post_rst_count", 32'(issued_count), 32'd0);
        send(4, 2, 3, 4, 0);
        drain();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
